// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived address-field widths and the line-fill state encoding.
package icache_pkg;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int LINES_DEF = 32;
   localparam int WORDS_DEF = 8;

   localparam int OFF_W = $clog2(WORDS_DEF);
   localparam int IDX_W = $clog2(LINES_DEF);
   localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the instruction cache: combinational lookup read,
// single-word synchronous fill write, and a valid array that alone is reset.
module icache_array
   import icache_pkg::*;
#(
   parameter  int LINES = LINES_DEF,
   parameter  int WORDS = WORDS_DEF,
   localparam int OW    = $clog2(WORDS),
   localparam int IW    = $clog2(LINES),
   localparam int TW    = ADDR_W - 1 - OW - IW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IW-1:0]     rd_index,
   input  logic [OW-1:0]     rd_offset,
   output logic              rd_valid,
   output logic [TW-1:0]     rd_tag,
   output logic [DATA_W-1:0] rd_word,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_index,
   input  logic [OW-1:0]     wr_offset,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              inval_en,
   input  logic              install_en,
   input  logic [TW-1:0]     install_tag
);

   logic [LINES-1:0]  valid;
   logic [TW-1:0]     tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES*WORDS];

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_word  = data_mem[{rd_index, rd_offset}];

   // A line is dropped when its refill starts so a half-written line never hits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (install_en) begin
         valid[wr_index] <= 1'b1;
      end else if (inval_en) begin
         valid[wr_index] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{wr_index, wr_offset}] <= wr_data;
      end
      if (install_en) begin
         tag_mem[wr_index] <= install_tag;
      end
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, and a line-fill
// FSM that streams a missing line from pipelined memory while stalling fetch.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = LINES_DEF,
   parameter int WORDS = WORDS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [15:0]       miss_count
);

   localparam int OW = $clog2(WORDS);
   localparam int IW = $clog2(LINES);
   localparam int TW = ADDR_W - 1 - OW - IW;
   localparam int CW = OW + 1;

   state_t        state;
   logic [IW-1:0] fill_idx;
   logic [TW-1:0] fill_tag;
   logic [CW-1:0] req_cnt;
   logic [CW-1:0] rsp_cnt;

   logic [OW-1:0]     lk_off;
   logic [IW-1:0]     lk_idx;
   logic [TW-1:0]     lk_tag;
   logic              addr_lsb_unused;
   logic              rd_valid;
   logic [TW-1:0]     rd_tag;
   logic [DATA_W-1:0] rd_word;
   logic              idle;
   logic              hit;
   logic              miss_start;
   logic              rsp_fire;
   logic              last_rsp;

   assign lk_off          = fetch_addr[OW:1];
   assign lk_idx          = fetch_addr[OW+IW:OW+1];
   assign lk_tag          = fetch_addr[ADDR_W-1:OW+IW+1];
   assign addr_lsb_unused = fetch_addr[0];

   assign idle        = (state == IDLE);
   assign hit         = fetch_en & rd_valid & (rd_tag == lk_tag);
   assign miss_start  = idle & fetch_en & ~hit;
   assign rsp_fire    = (state == FILL) & mem_rvalid;
   assign last_rsp    = rsp_fire & (rsp_cnt == CW'(WORDS - 1));

   assign instr_valid = hit & idle;
   assign instr       = instr_valid ? rd_word : '0;
   assign stall       = (fetch_en & ~hit) | ~idle;

   assign mem_req     = (state == FILL) & (req_cnt < CW'(WORDS));
   assign mem_addr    = {fill_tag, fill_idx, req_cnt[OW-1:0], 1'b0};

   icache_array #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_array (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_index    (lk_idx),
      .rd_offset   (lk_off),
      .rd_valid    (rd_valid),
      .rd_tag      (rd_tag),
      .rd_word     (rd_word),
      .wr_en       (rsp_fire),
      .wr_index    (idle ? lk_idx : fill_idx),
      .wr_offset   (rsp_cnt[OW-1:0]),
      .wr_data     (mem_rdata),
      .inval_en    (miss_start),
      .install_en  (last_rsp),
      .install_tag (fill_tag)
   );

   // Requests and responses are counted independently; the fill ends on the
   // last response, which also installs the tag through the array.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         fill_idx   <= '0;
         fill_tag   <= '0;
         req_cnt    <= '0;
         rsp_cnt    <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_start) begin
                  fill_idx <= lk_idx;
                  fill_tag <= lk_tag;
                  req_cnt  <= '0;
                  rsp_cnt  <= '0;
                  if (miss_count != 16'hFFFF) begin
                     miss_count <= miss_count + 16'd1;
                  end
                  state <= FILL;
               end
            end
            FILL: begin
               if (mem_req) begin
                  req_cnt <= req_cnt + CW'(1);
               end
               if (rsp_fire) begin
                  rsp_cnt <= rsp_cnt + CW'(1);
               end
               if (last_rsp) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetch streams,
// checked against a line-level cache model and a fixed-latency memory model.
module tb_icache;

   localparam int LINES      = 32;
   localparam int WORDS      = 8;
   localparam int MEM_LAT    = 4;
   localparam int LINE_BYTES = 2 * WORDS;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [15:0] fetch_addr;
   logic [15:0] instr;
   logic        instr_valid;
   logic        stall;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [15:0] miss_count;

   icache #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .fetch_addr  (fetch_addr),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_rvalid  (mem_rvalid),
      .miss_count  (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } rsp_t;

   rsp_t pend[$];
   int   tests;
   int   fails;
   int   cyc;
   bit   ref_valid [LINES];
   int   ref_tag   [LINES];
   int   ref_misses;

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return 16'hA000 + {1'b0, a[15:1]};
   endfunction

   function automatic int lineOf(input logic [15:0] a);
      return (int'(a) / LINE_BYTES) % LINES;
   endfunction

   function automatic int tagOf(input logic [15:0] a);
      return int'(a) / (LINE_BYTES * LINES);
   endfunction

   function automatic bit refHit(input logic [15:0] a);
      return ref_valid[lineOf(a)] && (ref_tag[lineOf(a)] == tagOf(a));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic refReset();
      for (int i = 0; i < LINES; i++) begin
         ref_valid[i] = 1'b0;
         ref_tag[i]   = 0;
      end
      ref_misses = 0;
   endtask

   // Memory model: requests seen before an edge answer MEM_LAT cycles later;
   // a reset edge drops everything in flight.
   task automatic tick();
      bit was_reset;
      was_reset = !rst_n;
      if (rst_n && mem_req) pend.push_back('{mem_addr, cyc + MEM_LAT});
      @(posedge clk);
      cyc++;
      #1;
      if (was_reset) pend.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = memWord(pend[0].addr);
         void'(pend.pop_front());
      end
   endtask

   task automatic idleCycle();
      fetch_en = 1'b0;
      #1;
      checkOutput("idle_stall", stall, 0);
      checkOutput("idle_ivalid", instr_valid, 0);
      checkOutput("idle_instr", instr, 0);
      checkOutput("idle_req", mem_req, 0);
      tick();
   endtask

   // One fetch until it hits; a redirect (redir_at > 0) switches the PC in
   // that fill cycle, after which the new PC is looked up.
   task automatic applyStimulus(input logic [15:0] addr, input int redir_at, input logic [15:0] redir_addr);
      logic [15:0] cur;
      logic [15:0] base;
      int          rat;
      cur = addr;
      rat = redir_at;
      for (int guard = 0; guard < 3; guard++) begin
         fetch_en   = 1'b1;
         fetch_addr = cur;
         #1;
         if (refHit(cur)) begin
            checkOutput("hit_stall", stall, 0);
            checkOutput("hit_ivalid", instr_valid, 1);
            checkOutput("hit_instr", instr, memWord(cur));
            tick();
            return;
         end
         checkOutput("miss_stall", stall, 1);
         checkOutput("miss_ivalid", instr_valid, 0);
         checkOutput("miss_instr", instr, 0);
         base = cur - 16'(int'(cur) % LINE_BYTES);
         if (ref_misses < 65535) ref_misses++;
         tick();
         for (int k = 1; k <= WORDS + MEM_LAT; k++) begin
            if (rat == k) cur = redir_addr;
            fetch_addr = cur;
            #1;
            checkOutput("fill_stall", stall, 1);
            checkOutput("fill_ivalid", instr_valid, 0);
            checkOutput("fill_req", mem_req, (k <= WORDS) ? 1 : 0);
            if (k <= WORDS) checkOutput("fill_addr", mem_addr, 32'(base) + 32'(2 * (k - 1)));
            tick();
         end
         ref_valid[lineOf(base)] = 1'b1;
         ref_tag[lineOf(base)]   = tagOf(base);
         checkOutput("miss_count", miss_count, ref_misses);
         rat = 0;
      end
   endtask

   function automatic logic [15:0] randAddr();
      return 16'($urandom_range(0, 3) * 512 + $urandom_range(0, 7) * 16 + $urandom_range(0, 7) * 2);
   endfunction

   initial begin
      tests      = 0;
      fails      = 0;
      cyc        = 0;
      rst_n      = 1'b0;
      fetch_en   = 1'b1;
      fetch_addr = 16'h0000;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      refReset();

      tick();
      tick();
      #1;
      checkOutput("rst_stall", stall, 1);
      checkOutput("rst_ivalid", instr_valid, 0);
      checkOutput("rst_instr", instr, 0);
      checkOutput("rst_req", mem_req, 0);
      checkOutput("rst_miss_count", miss_count, 0);
      rst_n    = 1'b1;
      fetch_en = 1'b0;
      tick();

      applyStimulus(16'h0000, 0, 16'h0000);
      for (int a = 2; a <= 14; a += 2) applyStimulus(16'(a), 0, 16'h0000);
      checkOutput("line_hits_miss_count", miss_count, 1);

      applyStimulus(16'h0200, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 16'h0000);
      checkOutput("conflict_miss_count", miss_count, 3);

      applyStimulus(16'h0040, 3, 16'h0100);
      applyStimulus(16'h0040, 0, 16'h0000);

      fetch_en   = 1'b0;
      fetch_addr = 16'h0000;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
      #1;
      checkOutput("spurious_stall", stall, 0);
      tick();
      applyStimulus(16'h0000, 0, 16'h0000);
      applyStimulus(16'h0002, 0, 16'h0000);
      applyStimulus(16'h0100, 0, 16'h0000);

      fetch_en   = 1'b1;
      fetch_addr = 16'h0300;
      #1;
      checkOutput("rstfill_first_miss", stall, refHit(16'h0300) ? 0 : 1);
      tick();
      for (int k = 1; k < 6; k++) tick();
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      fetch_en = 1'b0;
      #1;
      checkOutput("rstfill_req", mem_req, 0);
      checkOutput("rstfill_miss_count", miss_count, 0);
      checkOutput("rstfill_stall", stall, 0);
      refReset();
      tick();
      applyStimulus(16'h0300, 0, 16'h0000);
      applyStimulus(16'h0000, 0, 16'h0000);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            idleCycle();
         end else if ($urandom_range(0, 5) == 0) begin
            applyStimulus(randAddr(), int'($urandom_range(1, WORDS + MEM_LAT)), randAddr());
         end else begin
            applyStimulus(randAddr(), 0, 16'h0000);
         end
      end
      checkOutput("final_miss_count", miss_count, ref_misses);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the IF stage's PC register and a pipelined multi-cycle main memory. Hits return the instruction combinationally in the same cycle. A miss stalls the front end while a line-fill state machine streams the line in from memory and installs it. `stall` drives the PC register and IF/ID write enables, i.e. `wen = ~stall`.

## Interface
Parameters:
- `LINES`, 32: number of cache lines, power of two.
- `WORDS`, 8: 16-bit words per line, power of two.
- `MEM_LAT`, 4: fixed memory latency in cycles from request to response. Used by the bench only; the RTL must not depend on it.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `fetch_en`, in, 1: IF stage requests an instruction this cycle.
- `fetch_addr`, in, 16: byte address (PC); bit 0 ignored.
- `instr`, out, 16: instruction word; `16'h0000` when `instr_valid` is 0.
- `instr_valid`, out, 1: hit this cycle.
- `stall`, out, 1: front end must hold PC and IF/ID.
- `mem_req`, out, 1: read request, one word per cycle.
- `mem_addr`, out, 16: word-aligned request address.
- `mem_rdata`, in, 16: response data.
- `mem_rvalid`, in, 1: response valid; responses return in request order.
- `miss_count`, out, 16: saturating count of misses since reset.

## Operation
- Address split, with defaults in brackets:
  - offset = `fetch_addr[log2(WORDS):1]` [3:1]
  - index = next log2(LINES) bits [8:4]
  - tag = the remaining upper bits [15:9], 7 bits
- Hit = `fetch_en` and `valid[index]` and stored tag equals tag.
- `instr_valid` = hit while in IDLE.
- `stall` = (`fetch_en` and not hit) or (state ≠ IDLE).
- States:
  - IDLE:
    - On `fetch_en` and miss, latch base = `{tag, index, 0…0}`, clear `req_cnt` and `rsp_cnt`, increment `miss_count` (saturates at `16'hFFFF`), then go to FILL.
    - With `fetch_en` low, no action.
  - FILL:
    - Requests: `mem_req` = 1 while `req_cnt < WORDS`, with `mem_addr = base + 2*req_cnt`; `req_cnt` increments each such cycle.
    - Responses: each `mem_rvalid` writes `mem_rdata` into `data[index][rsp_cnt]`, then `rsp_cnt` increments.
    - Completion: on the response with `rsp_cnt == WORDS-1`, write the tag, set `valid[index]`, and go to IDLE.
- `valid[index]` stays 0 for the whole fill, so a partially written line never hits.
- `fetch_addr` changes during FILL (branch redirect): the fill completes for the latched line regardless. The new address is looked up in IDLE afterwards and may miss again.
- `mem_rvalid` in IDLE, or after `WORDS` responses, is ignored.
- A line is replaced only by a fill to the same index; there is no other invalidation.

## Timing
- Reset (`rst_n` low at an edge):
  - state = IDLE
  - all valid bits = 0
  - `req_cnt` = `rsp_cnt` = 0
  - `miss_count` = 0
  - `mem_req` = 0
  - `instr_valid` = 0
  - `instr` = 0
  - `stall` = `fetch_en` (all lines miss)
  - Data/tag arrays need no reset.
- Reset mid-fill aborts the fill. Main memory shares `rst_n` and discards in-flight responses, and the line stays invalid.
- Hit latency: 0 cycles (combinational from `fetch_addr`).
- Miss timeline, miss in cycle 0:
  - Requests in cycles 1..WORDS.
  - Last response in cycle WORDS+MEM_LAT.
  - Hit in the following cycle.
  - With defaults: `stall` high for cycles 0..12 and the hit in cycle 13, a 13-cycle penalty.
- `mem_req` issue is unthrottled. Memory accepts one request per cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, FILL)
  - the `LINES`/`WORDS` defaults
  - the derived widths: offset, index, tag
- One sub-module, `icache_array`, holds the storage:
  - valid, tag and data arrays
  - combinational read of tag, valid and the addressed word
  - synchronous single-word write plus tag/valid write
  - reset that clears valid only
- The top level contains the FSM, counters, address split and `miss_count`.

## Test plan
- Cold miss: reset, `fetch_en`=1, `fetch_addr`=`16'h0000`. Memory returns word k as `16'hA000+k`.
  - `mem_addr` 0,2,…,14 on cycles 1..8.
  - `stall` high for cycles 0..12.
  - Cycle 13: `instr`=`16'hA000`, `instr_valid`=1.
  - `miss_count`=1.
- Hits in line: after the cold fill, step `fetch_addr` 0x2,0x4,…,0xE.
  - Each returns `16'hA001`..`16'hA007` in the same cycle with `stall`=0.
  - `miss_count` stays 1.
- Conflict: fill 0x0000, then fetch 0x0200 (same index, tag 1).
  - Miss, fill from 0x0200..0x020E.
  - Refetch of 0x0000 misses again; `miss_count`=3.
- Redirect mid-fill: miss on 0x0040, change `fetch_addr` to 0x0100 at cycle 3.
  - Fill still requests 0x0040..0x004E.
  - Then a second miss fill for 0x0100.
  - 0x0040 hits afterwards.
- Reset mid-fill: assert `rst_n`=0 at cycle 6 of a fill.
  - Next cycle: `mem_req`=0, `miss_count`=0.
  - Refetch of the same address misses.
- Spurious response: pulse `mem_rvalid` in IDLE with `mem_rdata`=`16'hDEAD`.
  - No array change; prior hits unchanged.
